instr_word_encoder: RTL and testbench
=====================================

# instr_word_encoder

Encodes load-word (I-type) and store-word (S-type) operation descriptors into 32-bit RV32I instruction words. It packs the signed immediate into the instruction fields, which is the inverse of the core's immediate sign-extension. Each encoded word is written sequentially into instruction memory through a stallable write port. It sits between the bench/boot loader and the instruction memory, so test programs can be built from field values instead of hand-assembled hex.

## Interface
Parameters:
- AW, 32: byte-address width of the memory write port.
- BASE_ADDR, 32'h0000_0000: address of the first written word; must be 4-byte aligned.
- DEPTH, 64: maximum number of words written before the block reports full.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: address, count, error flag and pending word are all cleared.
- in_valid  in  1  a descriptor is present.
- in_ready  out  1  descriptor accepted on a cycle where in_valid && in_ready.
- in_store  in  1  1 = sw (S-type), 0 = lw (I-type).
- in_rd  in  5  destination register; used for lw only.
- in_rs1  in  5  base register.
- in_rs2  in  5  source register; used for sw only.
- in_imm  in  32  signed byte offset.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write on a cycle where mem_we && mem_ready.
- mem_addr  out  AW  word-aligned byte address.
- mem_wd  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  number of words committed to memory.
- full  out  1  count == DEPTH.
- err  out  1  sticky flag; set when a descriptor is rejected.

## Operation
- Range check: a descriptor is legal iff in_imm == sign-extension of in_imm[11:0].
  - An illegal descriptor is still consumed (in_ready handshake completes).
  - It produces no write; err is set and stays set until rst or clear.
- lw encoding: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
- sw encoding: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
- A one-entry output register holds the word awaiting memory.
- States:
  - EMPTY: no pending word.
  - PEND: mem_we = 1.
  - FULL: DEPTH words committed; terminal until rst or clear.
- Transitions:
  - EMPTY → PEND on a legal accept.
  - PEND → EMPTY on commit with no new legal accept.
  - PEND → PEND on commit with a simultaneous legal accept (back-to-back).
  - Any state → FULL when count reaches DEPTH.
- in_ready = !full && (state == EMPTY || mem_ready) && !clear. The full term accounts for words already pending.
- Address and count:
  - On each commit, mem_addr += 4 and count += 1.
  - mem_addr starts at BASE_ADDR.
  - No wrap-around; the block stops at DEPTH.
- clear has priority over every other event, including a same-cycle commit: the pending word is discarded and the state returns to EMPTY.

## Timing
- Reset values: in_ready = 1, mem_we = 0, mem_addr = BASE_ADDR, mem_wd = 0, count = 0, full = 0, err = 0.
- Latency:
  - The accept edge loads the output register.
  - mem_we rises in the following cycle.
  - One word per cycle is sustained while mem_ready stays high.
- While mem_we && !mem_ready, mem_addr and mem_wd are held stable.
- err is asserted in the cycle after the illegal accept.
- full asserts in the cycle after the DEPTH-th commit; in_ready is low from that same cycle.
- An rst assertion mid-write drops the pending word immediately and asynchronously. count does not include the dropped word.

## Structure
- Shared package rv_isa_pkg holds:
  - OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, F3_W = 3'b010.
  - Instruction-type enum (I, S).
  - The DEPTH-derived count width function.
- One combinational sub-module, imm_pack, holds the packer: inputs store, rd, rs1, rs2, imm[11:0]; outputs the 32-bit word and the legal flag. The top level owns the FSM, output register, address and count.

## Test plan
- lw, rd=5, rs1=2, imm=8 → mem_wd = 32'h0081_2283 at mem_addr = BASE_ADDR, one cycle after accept; count = 1.
- sw, rs2=6, rs1=2, imm=-4 → mem_wd = 32'hFE61_2E23 at BASE_ADDR+4.
- imm = 2048, then imm = -2049 → no mem_we, err = 1, mem_addr unchanged; a following legal lw still writes normally.
- mem_ready low for 3 cycles with in_valid continuously high → mem_wd/mem_addr stable and in_ready low; four back-to-back words commit at one per cycle once mem_ready returns.
- DEPTH = 4, five legal descriptors → four writes at 0x0/0x4/0x8/0xC, full = 1, fifth never accepted; clear → count = 0, address = BASE_ADDR, in_ready = 1.
- rst pulsed while mem_we = 1 and mem_ready = 0 → all outputs at reset values in the same cycle, no commit recorded.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants, instruction types and sizing helpers.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_W      = 3'b010;

  typedef enum logic {
    INSTR_I = 1'b0,
    INSTR_S = 1'b1
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_word_encoder_if.sv
// Descriptor input channel and instruction-memory write port of the encoder.
interface instr_word_encoder_if #(
  parameter int unsigned AW = 32
) ();

  logic          in_valid;
  logic          in_ready;
  logic          in_store;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;

  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;

  // Encoder side: consumes descriptors, produces memory writes.
  modport slave (
    input  in_valid, in_store, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wd
  );

  // Environment side: supplies descriptors and models the memory.
  modport master (
    output in_valid, in_store, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/instr_word_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into I- or S-type fields.
module imm_pack
  import rv_isa_pkg::*;
(
  input  logic        store,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  instr_type_e itype;

  assign itype = store ? INSTR_S : INSTR_I;

  // Legal only if the offset survives truncation to 12 bits and re-extension.
  assign legal = (imm == {{20{imm[11]}}, imm[11:0]});

  // Field placement for the two supported formats.
  always_comb begin
    word = '0;
    case (itype)
      INSTR_I: word = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
      INSTR_S: word = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Encodes lw/sw descriptors and writes them sequentially into instruction memory.
module instr_word_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   DEPTH     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  instr_word_encoder_if.slave           bus,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          err
);

  localparam int unsigned    CW      = count_width(DEPTH);
  localparam logic [CW:0]    DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]  LAST    = CW'(DEPTH - 1);

  enc_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [31:0]   packed_word;
  logic          packed_legal;
  logic          pend;
  logic          commit;
  logic          room;
  logic          ready_c;
  logic          accept;
  logic          acc_legal;
  logic          acc_bad;

  imm_pack u_pack (
    .store (bus.in_store),
    .rd    (bus.in_rd),
    .rs1   (bus.in_rs1),
    .rs2   (bus.in_rs2),
    .imm   (bus.in_imm),
    .word  (packed_word),
    .legal (packed_legal)
  );

  // Handshake qualifiers; room counts the pending word against the depth limit.
  assign pend      = (state_q == ST_PEND);
  assign commit    = pend && bus.mem_ready;
  assign room      = ({1'b0, count_q} + (CW+1)'(pend)) < DEPTH_X;
  assign ready_c   = room && ((state_q == ST_EMPTY) || bus.mem_ready) && !clear;
  assign accept    = bus.in_valid && ready_c;
  assign acc_legal = accept && packed_legal;
  assign acc_bad   = accept && !packed_legal;

  // State, output register, address and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      addr_q  <= BASE_ADDR;
      wd_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; clear overrides any same-cycle accept or commit.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      state_d = ST_EMPTY;
      addr_d  = BASE_ADDR;
      wd_d    = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (acc_bad) begin
        err_d = 1'b1;
      end
      if (acc_legal) begin
        wd_d = packed_word;
      end
      if (commit) begin
        addr_d  = addr_q + AW'(4);
        count_d = count_q + CW'(1);
      end
      case (state_q)
        ST_EMPTY: begin
          if (acc_legal) begin
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          if (commit) begin
            if (count_q == LAST) begin
              state_d = ST_FULL;
            end else if (!acc_legal) begin
              state_d = ST_EMPTY;
            end
          end
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready = ready_c;
  assign bus.mem_we   = pend;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wd   = wd_q;
  assign count        = count_q;
  assign full         = (state_q == ST_FULL);
  assign err          = err_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: table vectors, corner sequences, random traffic.
module tb_instr_word_encoder;
  import rv_isa_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int          DEPTH = 4;
  localparam int unsigned CW    = count_width(DEPTH);
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          clear = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          err;

  instr_word_encoder_if #(.AW(AW)) bus ();

  instr_word_encoder #(.AW(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  // Reference model: committed words, one optional pending word, sticky error.
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_word;
  bit          m_err;

  typedef struct {
    logic        st;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        legal;
  } vec_t;

  vec_t vt[7];

  function automatic bit legal_imm(input logic [31:0] imm);
    int v;
    v = int'($signed(imm));
    return (v >= -2048) && (v <= 2047);
  endfunction

  function automatic logic [31:0] enc(input logic st, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    if (!st)
      w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
    else
      w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd2 << 12)
          | ((imm & 32'h1F) << 7) | 32'h23;
    return w;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_pend = 1'b0;
    m_word = '0;
    m_err  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("mem_we", 32'(bus.mem_we), 32'(m_pend));
    chk("mem_addr", bus.mem_addr, BASE + 32'(m_cnt * 4));
    if (m_pend) chk("mem_wd", bus.mem_wd, m_word);
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // One clock: drive, check in_ready, advance the model, check registered outputs.
  task automatic cycle(input logic v, input logic st, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic mr,
                       input logic clr, output logic acc);
    logic exp_rdy;
    logic commit;
    logic ok;
    bus.in_valid  = v;
    bus.in_store  = st;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.mem_ready = mr;
    clear         = clr;
    #1;
    exp_rdy = ((m_cnt + int'(m_pend)) < DEPTH) && (!m_pend || mr) && !clr;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = v && bus.in_ready;
    if (bus.mem_we && mr && !clr) writes++;
    ok = legal_imm(imm);
    if (clr) begin
      model_reset();
    end else begin
      commit = m_pend && mr;
      if (commit) m_cnt++;
      if (v && exp_rdy && !ok) m_err = 1'b1;
      if (v && exp_rdy && ok) begin
        m_pend = 1'b1;
        m_word = enc(st, rd, rs1, rs2, imm);
      end else if (commit) begin
        m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic mr);
    logic a;
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, mr, 1'b0, a);
  endtask

  task automatic do_clear();
    logic a;
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b1, a);
  endtask

  initial begin
    logic        a;
    logic        mr;
    logic [11:0] t12;
    logic [31:0] imm;
    int          idx;
    int          w0;
    logic [31:0] bnd[4];

    vt[0] = '{1'b0, 5'd5,  5'd2,  5'd0,  32'd8,          32'h0081_2283, 1'b1};
    vt[1] = '{1'b1, 5'd0,  5'd2,  5'd6,  -32'sd4,        32'hFE61_2E23, 1'b1};
    vt[2] = '{1'b0, 5'd1,  5'd0,  5'd0,  32'hFFFF_FFFF,  32'hFFF0_2083, 1'b1};
    vt[3] = '{1'b1, 5'd0,  5'd31, 5'd31, 32'd2047,       32'h7FFF_AFA3, 1'b1};
    vt[4] = '{1'b0, 5'd0,  5'd0,  5'd0,  -32'sd2048,     32'h8000_2003, 1'b1};
    vt[5] = '{1'b0, 5'd5,  5'd2,  5'd0,  32'd2048,       32'h0,         1'b0};
    vt[6] = '{1'b1, 5'd0,  5'd2,  5'd6,  -32'sd2049,     32'h0,         1'b0};
    bnd[0] = 32'd2047; bnd[1] = 32'd2048; bnd[2] = -32'sd2048; bnd[3] = -32'sd2049;

    bus.in_valid = 1'b0; bus.in_store = 1'b0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_imm = '0; bus.mem_ready = 1'b1;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, BASE);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Table: one descriptor per vector, checked the cycle after accept.
    for (int i = 0; i < 7; i++) begin
      do_clear();
      cycle(1'b1, vt[i].st, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, 1'b1, 1'b0, a);
      chk("tbl_accept", 32'(a), 32'd1);
      chk("tbl_we", 32'(bus.mem_we), 32'(vt[i].legal));
      if (vt[i].legal) chk("tbl_wd", bus.mem_wd, vt[i].word);
      chk("tbl_err", 32'(err), 32'(!vt[i].legal));
      chk("tbl_addr", bus.mem_addr, BASE);
      idle(1'b1);
    end

    // lw then sw back to back: second word lands at BASE+4.
    do_clear();
    cycle(1'b1, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1, 1'b0, a);
    cycle(1'b1, 1'b1, 5'd0, 5'd2, 5'd6, -32'sd4, 1'b1, 1'b0, a);
    chk("seq_count1", 32'(count), 32'd1);
    chk("seq_addr", bus.mem_addr, BASE + 32'd4);
    chk("seq_wd", bus.mem_wd, 32'hFE61_2E23);
    idle(1'b1);
    chk("seq_count2", 32'(count), 32'd2);

    // Out-of-range immediates are consumed without a write; a later lw still writes.
    do_clear();
    cycle(1'b1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b1, 1'b0, a);
    chk("ill_accept", 32'(a), 32'd1);
    cycle(1'b1, 1'b1, 5'd0, 5'd1, 5'd1, -32'sd2049, 1'b1, 1'b0, a);
    chk("ill_we", 32'(bus.mem_we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_addr", bus.mem_addr, BASE);
    cycle(1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'd16, 1'b1, 1'b0, a);
    chk("ill_then_we", 32'(bus.mem_we), 32'd1);
    idle(1'b1);
    chk("ill_then_count", 32'(count), 32'd1);

    // Stall three cycles with in_valid held, then four words back to back.
    do_clear();
    w0 = writes;
    idx = 0;
    for (int c = 0; c < 30 && !(idx == 4 && !m_pend); c++) begin
      mr = !(c >= 1 && c <= 3);
      cycle(idx < 4, idx[0], 5'(idx + 1), 5'(idx + 2), 5'(idx + 3), 32'(idx * 4), mr, 1'b0, a);
      if (c >= 1 && c <= 3) chk("stall_ready", 32'(bus.in_ready), 32'd0);
      if (a) idx++;
    end
    chk("stall_words", 32'(writes - w0), 32'd4);
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_full", 32'(full), 32'd1);

    // Five descriptors against DEPTH=4: the fifth is never accepted.
    do_clear();
    w0 = writes;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(idx < 5, 1'b0, 5'(idx), 5'd1, 5'd0, 32'(idx), 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("depth_writes", 32'(writes - w0), 32'd4);
    chk("depth_accepts", 32'(idx), 32'd4);
    chk("depth_full", 32'(full), 32'd1);
    do_clear();
    idle(1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_addr", bus.mem_addr, BASE);
    chk("clr_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset while a write is stalled.
    cycle(1'b1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd4096, 1'b1, 1'b0, a);
    cycle(1'b1, 1'b0, 5'd7, 5'd8, 5'd0, 32'd12, 1'b0, 1'b0, a);
    idle(1'b0);
    chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("arst_mem_addr", bus.mem_addr, BASE);
    chk("arst_mem_wd", bus.mem_wd, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: begin t12 = 12'($urandom); imm = {{20{t12[11]}}, t12}; end
        1: imm = $urandom;
        2: imm = bnd[$urandom_range(0, 3)];
        default: imm = 32'($urandom_range(0, 64));
      endcase
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
            5'($urandom), imm, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
